redundant_alu_pipe: RTL and testbench

//  Sequential, parametrised successor to the combinational DMR ALU. Executes one 8-opcode ALU op per

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_core.sv | 29 ++
 rtl/redundant_alu_pipe.sv | 154 +++++++++++++++
 tb/tb_redundant_alu_pipe.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM state definitions shared by the redundant ALU pipe
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational 8-opcode ALU datapath, one instance per redundant copy
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] y
);

  // Arithmetic wraps modulo 2^WIDTH; shifts are logical and fill with zero
  always_comb begin
    y = '0;
    case (opcode)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      OP_SHL:  y = a << 1;
      OP_SHR:  y = a >> 1;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/redundant_alu_pipe.sv
// rtl/redundant_alu_pipe.sv - DMR-retry / TMR-vote ALU with valid/ready handshake and error counter
module redundant_alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int REDUNDANCY = 2,
  parameter int MAX_RETRY  = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  input  logic [2:0]                  opcode,
  input  logic [REDUNDANCY*WIDTH-1:0] fault_mask,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            result,
  output logic                        err_detect,
  output logic                        err_fatal,
  output logic [ERR_CNT_W-1:0]        err_count,
  input  logic                        err_clr
);

  if (REDUNDANCY != 2 && REDUNDANCY != 3) begin : g_bad_redundancy
    $error("redundant_alu_pipe: REDUNDANCY must be 2 or 3");
  end
  if (MAX_RETRY < 0 || MAX_RETRY > 7) begin : g_bad_retry
    $error("redundant_alu_pipe: MAX_RETRY must be in 0..7");
  end

  localparam bit         IS_TMR    = (REDUNDANCY == 3);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2:0]           op_q;
  logic [2:0]           retry_q;
  logic [WIDTH-1:0]     result_q;
  logic                 detect_q, fatal_q;
  logic [ERR_CNT_W-1:0] err_count_q;

  logic                 accept, exec_done, retry_inc;
  logic                 disagree, no_pair;
  logic [WIDTH-1:0]     majority;
  logic [WIDTH-1:0]     copy [3];

  // Copies beyond REDUNDANCY mirror copy 0 so the voter collapses to a plain DMR compare
  for (genvar k = 0; k < 3; k++) begin : g_copy
    if (k < REDUNDANCY) begin : g_core
      logic [WIDTH-1:0] y;
      alu_core #(.WIDTH(WIDTH)) u_core (
        .a      (a_q),
        .b      (b_q),
        .opcode (op_q),
        .y      (y)
      );
      assign copy[k] = y ^ fault_mask[k*WIDTH +: WIDTH];
    end else begin : g_fill
      assign copy[k] = copy[0];
    end
  end

  // Comparator and bitwise majority voter across the copies
  always_comb begin
    disagree = (copy[0] != copy[1]) || (copy[0] != copy[2]);
    no_pair  = (copy[0] != copy[1]) && (copy[0] != copy[2]) && (copy[1] != copy[2]);
    majority = (copy[0] & copy[1]) | (copy[0] & copy[2]) | (copy[1] & copy[2]);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state and per-cycle control strobes
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    exec_done = 1'b0;
    retry_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (IS_TMR || !disagree || retry_q == RETRY_MAX) begin
          exec_done = 1'b1;
          state_d   = ST_DONE;
        end else begin
          retry_inc = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture, retry tracking and result/flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      retry_q  <= '0;
      result_q <= '0;
      detect_q <= 1'b0;
      fatal_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_q      <= a;
        b_q      <= b;
        op_q     <= opcode;
        retry_q  <= '0;
        detect_q <= 1'b0;
        fatal_q  <= 1'b0;
      end
      if (state_q == ST_EXEC) begin
        if (disagree)  detect_q <= 1'b1;
        if (retry_inc) retry_q  <= retry_q + 3'd1;
        if (exec_done) begin
          // DMR reaches exec_done with a disagreement only once retries are exhausted
          result_q <= IS_TMR ? majority : copy[0];
          fatal_q  <= IS_TMR ? no_pair  : disagree;
        end
      end
    end
  end

  // Saturating disagreement counter; clear takes priority over increment
  always_ff @(posedge clk) begin
    if (!rst_n || err_clr) begin
      err_count_q <= '0;
    end else if (state_q == ST_EXEC && disagree && err_count_q != {ERR_CNT_W{1'b1}}) begin
      err_count_q <= err_count_q + 1'b1;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign result     = result_q;
  assign err_detect = detect_q;
  assign err_fatal  = fatal_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_redundant_alu_pipe.sv
// tb/tb_redundant_alu_pipe.sv - self-checking bench for DMR and TMR builds of redundant_alu_pipe
module tb_redundant_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, err_clr, out_ready, iv, sel;
  logic [7:0]  a, b;
  logic [2:0]  opcode;
  logic [23:0] cur_mask;

  logic        in_valid_d, in_valid_t;
  logic [15:0] mask_d;
  logic [23:0] mask_t;
  assign in_valid_d = iv & ~sel;
  assign in_valid_t = iv & sel;
  assign mask_d     = sel ? 16'h0 : cur_mask[15:0];
  assign mask_t     = sel ? cur_mask : 24'h0;

  logic       ir_d, ov_d, det_d, fat_d, ir_t, ov_t, det_t, fat_t;
  logic [7:0] res_d, res_t, cnt_d;
  logic [1:0] cnt_t;

  redundant_alu_pipe #(.WIDTH(8), .REDUNDANCY(2), .MAX_RETRY(2), .ERR_CNT_W(8)) dut_dmr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d), .in_ready(ir_d),
    .a(a), .b(b), .opcode(opcode), .fault_mask(mask_d),
    .out_valid(ov_d), .out_ready(out_ready), .result(res_d),
    .err_detect(det_d), .err_fatal(fat_d), .err_count(cnt_d), .err_clr(err_clr)
  );

  redundant_alu_pipe #(.WIDTH(8), .REDUNDANCY(3), .MAX_RETRY(2), .ERR_CNT_W(2)) dut_tmr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_t), .in_ready(ir_t),
    .a(a), .b(b), .opcode(opcode), .fault_mask(mask_t),
    .out_valid(ov_t), .out_ready(out_ready), .result(res_t),
    .err_detect(det_t), .err_fatal(fat_t), .err_count(cnt_t), .err_clr(err_clr)
  );

  logic       ir, ov, det, fat;
  logic [7:0] res, cnt;
  assign ir  = sel ? ir_t  : ir_d;
  assign ov  = sel ? ov_t  : ov_d;
  assign det = sel ? det_t : det_d;
  assign fat = sel ? fat_t : fat_d;
  assign res = sel ? res_t : res_d;
  assign cnt = sel ? {6'b0, cnt_t} : cnt_d;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int model_cnt_d = 0;
  int model_cnt_t = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] alu_ref(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op);
    int s;
    case (op)
      3'd0: s = (int'(x) + int'(y)) % 256;
      3'd1: s = (int'(x) - int'(y) + 256) % 256;
      3'd2: s = int'(x & y);
      3'd3: s = int'(x | y);
      3'd4: s = int'(x ^ y);
      3'd5: s = 255 - int'(x);
      3'd6: s = (int'(x) * 2) % 256;
      default: s = int'(x) / 2;
    endcase
    return 8'(s);
  endfunction

  // One transaction: m0/m1/m2 are the fault masks for successive EXEC cycles
  task automatic run_op(input bit tmr, input logic [7:0] ta, input logic [7:0] tb_, input logic [2:0] top,
                        input logic [23:0] m0, input logic [23:0] m1, input logic [23:0] m2,
                        input int hold, input bit clr, input string tag);
    logic [7:0]  gold, c0, c1, c2, e_res;
    logic [23:0] m;
    bit          e_det, e_fat;
    int          execs, lat, idx, ones;
    gold = alu_ref(ta, tb_, top);
    e_det = 0; e_fat = 0; e_res = 0; execs = 0;
    if (!tmr) begin
      for (int i = 0; i < 3; i++) begin
        m  = (i == 0) ? m0 : (i == 1) ? m1 : m2;
        c0 = gold ^ m[7:0];
        c1 = gold ^ m[15:8];
        execs++;
        if (clr && i == 0) begin model_cnt_d = 0; model_cnt_t = 0; end
        else if (c0 != c1 && model_cnt_d < 255) model_cnt_d++;
        if (c0 == c1) begin e_res = c0; break; end
        e_det = 1;
        if (i == 2) begin e_res = c0; e_fat = 1; break; end
      end
    end else begin
      c0 = gold ^ m0[7:0]; c1 = gold ^ m0[15:8]; c2 = gold ^ m0[23:16];
      execs = 1;
      for (int k = 0; k < 8; k++) begin
        ones = int'(c0[k]) + int'(c1[k]) + int'(c2[k]);
        e_res[k] = (ones >= 2);
      end
      e_det = (c0 != c1) || (c0 != c2);
      e_fat = (c0 != c1) && (c0 != c2) && (c1 != c2);
      if (clr) begin model_cnt_d = 0; model_cnt_t = 0; end
      else if (e_det && model_cnt_t < 3) model_cnt_t++;
    end

    sel = tmr; a = ta; b = tb_; opcode = top; iv = 1'b1;
    check({tag, "_in_ready"}, 32'(ir), 32'd1);
    @(posedge clk); @(negedge clk);
    iv = 1'b0; a = 8'($urandom); b = 8'($urandom); opcode = 3'($urandom);
    lat = 1; idx = 0;
    while (!ov && lat < 12) begin
      cur_mask = (idx == 0) ? m0 : (idx == 1) ? m1 : m2;
      err_clr  = clr && (idx == 0);
      idx++;
      @(posedge clk); @(negedge clk);
      lat++;
    end
    cur_mask = 24'h0; err_clr = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(1 + execs));
    check({tag, "_result"}, 32'(res), 32'(e_res));
    check({tag, "_detect"}, 32'(det), 32'(e_det));
    check({tag, "_fatal"}, 32'(fat), 32'(e_fat));
    check({tag, "_err_count"}, 32'(cnt), tmr ? 32'(model_cnt_t) : 32'(model_cnt_d));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      check({tag, "_hold_valid"}, 32'(ov), 32'd1);
      check({tag, "_hold_in_ready"}, 32'(ir), 32'd0);
      check({tag, "_hold_result"}, 32'(res), 32'(e_res));
      check({tag, "_hold_flags"}, {30'd0, det, fat}, {30'd0, e_det, e_fat});
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drop_valid"}, 32'(ov), 32'd0);
    check({tag, "_back_idle"}, 32'(ir), 32'd1);
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic [2:0]  rop, rsel;
    logic [23:0] rm [3];
    bit          rtmr;

    rst_n = 1'b0; err_clr = 1'b0; out_ready = 1'b0; iv = 1'b0; sel = 1'b0;
    a = 8'h0; b = 8'h0; opcode = 3'h0; cur_mask = 24'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_dmr", {ir_d, ov_d, det_d, fat_d, res_d, cnt_d}, {1'b1, 3'b000, 16'h0000});
    check("reset_tmr", {ir_t, ov_t, det_t, fat_t, res_t, 6'd0, cnt_t}, {1'b1, 3'b000, 16'h0000});
    rst_n = 1'b1;

    run_op(0, 8'h0F, 8'h01, 3'd0, 24'h0, 24'h0, 24'h0, 0, 0, "t1_dmr_clean");
    check("t1_value", 32'(res_d), 32'h10);
    run_op(0, 8'h0F, 8'h01, 3'd0, 24'h000100, 24'h0, 24'h0, 0, 0, "t2_dmr_retry");
    run_op(0, 8'h0F, 8'h01, 3'd0, 24'h000100, 24'h000100, 24'h000100, 1, 0, "t3_dmr_fatal");
    run_op(1, 8'hAA, 8'h00, 3'd5, 24'hFF0000, 24'h0, 24'h0, 0, 0, "t4_tmr_vote");
    run_op(1, 8'hAA, 8'h00, 3'd5, 24'h040201, 24'h0, 24'h0, 0, 0, "t4_tmr_fatal");
    run_op(1, 8'h3C, 8'h5A, 3'd1, 24'h000080, 24'h0, 24'h0, 5, 0, "t5_tmr_hold");
    run_op(1, 8'h81, 8'h7F, 3'd6, 24'h100000, 24'h0, 24'h0, 0, 0, "t5_tmr_saturate");
    run_op(0, 8'hF0, 8'h0F, 3'd3, 24'h0, 24'h0, 24'h0, 5, 0, "t5_dmr_hold");
    run_op(1, 8'h12, 8'h34, 3'd4, 24'h000800, 24'h0, 24'h0, 0, 1, "t5_clr_wins");

    // Reset in the middle of EXEC with a live disagreement
    sel = 1'b0; a = 8'h55; b = 8'h22; opcode = 3'd0; iv = 1'b1;
    @(posedge clk); @(negedge clk);
    iv = 1'b0; cur_mask = 24'h000100; rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; cur_mask = 24'h0;
    model_cnt_d = 0; model_cnt_t = 0;
    check("t6_out_valid", 32'(ov_d), 32'd0);
    check("t6_in_ready", 32'(ir_d), 32'd1);
    check("t6_err_count", 32'(cnt_d), 32'd0);
    check("t6_result", 32'(res_d), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      check("t6_no_stale", 32'(ov_d), 32'd0);
    end

    for (int n = 0; n < 40; n++) begin
      rtmr = 1'($urandom);
      ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom);
      for (int j = 0; j < 3; j++) begin
        rsel  = 3'($urandom_range(0, 7));
        rm[j] = 24'($urandom) & {{8{rsel[2]}}, {8{rsel[1]}}, {8{rsel[0]}}};
        if ($urandom_range(0, 2) == 0) rm[j] = 24'h0;
      end
      run_op(rtmr, ra, rb, rop, rm[0], rm[1], rm[2], $urandom_range(0, 2),
             ($urandom_range(0, 7) == 0), "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
